// File: rtl/rs_wakeup_select.sv
`default_nettype none
// ============================================================================
//  Module      : rs_wakeup_select
//  Description : Reservation station with CDB wakeup, insert forwarding and
//                oldest-ready dispatch into a registered valid/ready FU port.
//                Optional flush port enabled by defining RS_FLUSH_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module rs_wakeup_select #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3,
    parameter int FUNC_W = 4,
    parameter int REG_W  = 4
) (
    input  logic                         clk1,
    input  logic                         rst,
`ifdef RS_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic                         iss_valid,
    output logic                         iss_ready,
    input  logic [FUNC_W-1:0]            iss_func,
    input  logic [TAG_W-1:0]             iss_rob,
    input  logic [REG_W-1:0]             iss_rd,
    input  logic                         iss_q1b,
    input  logic [TAG_W-1:0]             iss_q1,
    input  logic [DATA_W-1:0]            iss_v1,
    input  logic                         iss_q2b,
    input  logic [TAG_W-1:0]             iss_q2,
    input  logic [DATA_W-1:0]            iss_v2,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_data,
    output logic                         fu_valid,
    input  logic                         fu_ready,
    output logic [FUNC_W-1:0]            fu_func,
    output logic [TAG_W-1:0]             fu_rob,
    output logic [REG_W-1:0]             fu_rd,
    output logic [DATA_W-1:0]            fu_a,
    output logic [DATA_W-1:0]            fu_b,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry storage
    logic              r_busy [DEPTH];
    logic [FUNC_W-1:0] r_func [DEPTH];
    logic [TAG_W-1:0]  r_rob  [DEPTH];
    logic [REG_W-1:0]  r_rd   [DEPTH];
    logic              r_q1b  [DEPTH];
    logic [TAG_W-1:0]  r_q1   [DEPTH];
    logic [DATA_W-1:0] r_v1   [DEPTH];
    logic              r_q2b  [DEPTH];
    logic [TAG_W-1:0]  r_q2   [DEPTH];
    logic [DATA_W-1:0] r_v2   [DEPTH];
    logic [IDX_W-1:0]  r_age  [DEPTH];

    // Output register
    logic              r_fu_valid;
    logic [FUNC_W-1:0] r_fu_func;
    logic [TAG_W-1:0]  r_fu_rob;
    logic [REG_W-1:0]  r_fu_rd;
    logic [DATA_W-1:0] r_fu_a;
    logic [DATA_W-1:0] r_fu_b;

    logic              w_flush;
    logic [OCC_W-1:0]  w_occ;
    logic              w_rdy [DEPTH];
    logic              w_sel_found;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [IDX_W-1:0]  w_sel_age;
    logic              w_free_found;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_load;
    logic              w_disp;
    logic              w_ins;
    logic [IDX_W-1:0]  w_new_age;
    logic              w_fwd1;
    logic              w_fwd2;

`ifdef RS_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(r_busy[i]);
        end
    end

    assign occupancy = w_occ;
    assign iss_ready = (w_occ < OCC_W'(DEPTH));

    // Ages of busy entries are always a dense 0..occ-1, so the minimum-age
    // ready entry is unique.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sel_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rdy[i] = r_busy[i] && !r_q1b[i] && !r_q2b[i];
            if (w_rdy[i] && (!w_sel_found || (r_age[i] < w_sel_age))) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
                w_sel_age   = r_age[i];
            end
        end
    end

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r_busy[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    assign w_load    = !r_fu_valid || fu_ready;
    assign w_disp    = w_load && w_sel_found;
    assign w_ins     = iss_valid && iss_ready && w_free_found && !w_flush;
    // The dispatched entry is always older than a new arrival.
    assign w_new_age = IDX_W'(w_occ - OCC_W'(w_disp));
    assign w_fwd1    = iss_q1b && cdb_valid && (cdb_tag == iss_q1);
    assign w_fwd2    = iss_q2b && cdb_valid && (cdb_tag == iss_q2);

    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i] <= 1'b0;
                r_func[i] <= '0;
                r_rob[i]  <= '0;
                r_rd[i]   <= '0;
                r_q1b[i]  <= 1'b0;
                r_q1[i]   <= '0;
                r_v1[i]   <= '0;
                r_q2b[i]  <= 1'b0;
                r_q2[i]   <= '0;
                r_v2[i]   <= '0;
                r_age[i]  <= '0;
            end
            r_fu_valid <= 1'b0;
            r_fu_func  <= '0;
            r_fu_rob   <= '0;
            r_fu_rd    <= '0;
            r_fu_a     <= '0;
            r_fu_b     <= '0;
        end else if (w_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i] <= 1'b0;
                r_age[i]  <= '0;
            end
            r_fu_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_disp && (w_sel_idx == IDX_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end else if (r_busy[i]) begin
                    if (cdb_valid && r_q1b[i] && (r_q1[i] == cdb_tag)) begin
                        r_q1b[i] <= 1'b0;
                        r_v1[i]  <= cdb_data;
                    end
                    if (cdb_valid && r_q2b[i] && (r_q2[i] == cdb_tag)) begin
                        r_q2b[i] <= 1'b0;
                        r_v2[i]  <= cdb_data;
                    end
                    if (w_disp && (r_age[i] > w_sel_age)) begin
                        r_age[i] <= r_age[i] - IDX_W'(1);
                    end
                end
                if (w_ins && (w_free_idx == IDX_W'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_func[i] <= iss_func;
                    r_rob[i]  <= iss_rob;
                    r_rd[i]   <= iss_rd;
                    r_q1b[i]  <= iss_q1b && !w_fwd1;
                    r_q1[i]   <= iss_q1;
                    r_v1[i]   <= w_fwd1 ? cdb_data : iss_v1;
                    r_q2b[i]  <= iss_q2b && !w_fwd2;
                    r_q2[i]   <= iss_q2;
                    r_v2[i]   <= w_fwd2 ? cdb_data : iss_v2;
                    r_age[i]  <= w_new_age;
                end
            end

            if (w_load) begin
                if (w_sel_found) begin
                    r_fu_valid <= 1'b1;
                    r_fu_func  <= r_func[w_sel_idx];
                    r_fu_rob   <= r_rob[w_sel_idx];
                    r_fu_rd    <= r_rd[w_sel_idx];
                    r_fu_a     <= r_v1[w_sel_idx];
                    r_fu_b     <= r_v2[w_sel_idx];
                end else begin
                    r_fu_valid <= 1'b0;
                end
            end
        end
    end

    assign fu_valid = r_fu_valid;
    assign fu_func  = r_fu_func;
    assign fu_rob   = r_fu_rob;
    assign fu_rd    = r_fu_rd;
    assign fu_a     = r_fu_a;
    assign fu_b     = r_fu_b;

endmodule
`default_nettype wire

// File: tb/tb_rs_wakeup_select.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_wakeup_select
//  Description : Directed scoreboard bench for rs_wakeup_select.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rs_wakeup_select;

    typedef struct packed {
        logic [3:0]  func;
        logic [2:0]  rob;
        logic [3:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    logic        clk1 = 1'b0;
    logic        rst  = 1'b1;
`ifdef RS_FLUSH_EN
    logic        flush = 1'b0;
`endif
    logic        iss_valid = 1'b0;
    logic        iss_ready;
    logic [3:0]  iss_func  = '0;
    logic [2:0]  iss_rob   = '0;
    logic [3:0]  iss_rd    = '0;
    logic        iss_q1b   = 1'b0;
    logic [2:0]  iss_q1    = '0;
    logic [15:0] iss_v1    = '0;
    logic        iss_q2b   = 1'b0;
    logic [2:0]  iss_q2    = '0;
    logic [15:0] iss_v2    = '0;
    logic        cdb_valid = 1'b0;
    logic [2:0]  cdb_tag   = '0;
    logic [15:0] cdb_data  = '0;
    logic        fu_valid;
    logic        fu_ready  = 1'b0;
    logic [3:0]  fu_func;
    logic [2:0]  fu_rob;
    logic [3:0]  fu_rd;
    logic [15:0] fu_a;
    logic [15:0] fu_b;
    logic [1:0]  occupancy;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    rs_wakeup_select #(
        .DEPTH(2), .DATA_W(16), .TAG_W(3), .FUNC_W(4), .REG_W(4)
    ) dut (
        .clk1      (clk1),
        .rst       (rst),
`ifdef RS_FLUSH_EN
        .flush     (flush),
`endif
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_func  (iss_func),
        .iss_rob   (iss_rob),
        .iss_rd    (iss_rd),
        .iss_q1b   (iss_q1b),
        .iss_q1    (iss_q1),
        .iss_v1    (iss_v1),
        .iss_q2b   (iss_q2b),
        .iss_q2    (iss_q2),
        .iss_v2    (iss_v2),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .fu_valid  (fu_valid),
        .fu_ready  (fu_ready),
        .fu_func   (fu_func),
        .fu_rob    (fu_rob),
        .fu_rd     (fu_rd),
        .fu_a      (fu_a),
        .fu_b      (fu_b),
        .occupancy (occupancy)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed handshake must match the head of the scoreboard.
    always @(negedge clk1) begin
        if (!rst && fu_valid === 1'b1 && fu_ready === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_dispatch: got rob=%0h a=%0h b=%0h expected none",
                         fu_rob, fu_a, fu_b);
            end else begin
                exp_t e;
                exp_t g;
                e = sb_q.pop_front();
                g = '{func: fu_func, rob: fu_rob, rd: fu_rd, a: fu_a, b: fu_b};
                if (g !== e) begin
                    bad++;
                    $display("FAIL dispatch: got f=%0h rob=%0h rd=%0h a=%0h b=%0h expected f=%0h rob=%0h rd=%0h a=%0h b=%0h",
                             g.func, g.rob, g.rd, g.a, g.b, e.func, e.rob, e.rd, e.a, e.b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic issue(input logic [3:0] f, input logic [2:0] rob, input logic [3:0] rd,
                         input logic q1b, input logic [2:0] q1, input logic [15:0] v1,
                         input logic q2b, input logic [2:0] q2, input logic [15:0] v2);
        iss_valid = 1'b1; iss_func = f; iss_rob = rob; iss_rd = rd;
        iss_q1b = q1b; iss_q1 = q1; iss_v1 = v1;
        iss_q2b = q2b; iss_q2 = q2; iss_v2 = v2;
    endtask

    task automatic fill_and_stall();
        fu_ready = 1'b0;
        issue(4'h7, 3'd1, 4'h1, 1'b0, 3'd0, 16'h1111, 1'b0, 3'd0, 16'h2222);
        tick();
        issue(4'h7, 3'd2, 4'h2, 1'b1, 3'd3, 16'h0, 1'b0, 3'd0, 16'h3333);
        tick();
        issue(4'h7, 3'd3, 4'h3, 1'b1, 3'd3, 16'h0, 1'b0, 3'd0, 16'h4444);
        tick();
        iss_valid = 1'b0;
        chk("pre_clear_valid", 32'(fu_valid), 32'd1);
        chk("pre_clear_occ",   32'(occupancy), 32'd2);
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        chk("rst_fu_valid", 32'(fu_valid), 32'd0);
        chk("rst_occ",      32'(occupancy), 32'd0);
        chk("rst_iss_ready", 32'(iss_ready), 32'd1);
        chk("rst_fu_a",     32'(fu_a), 32'd0);

        // 1: ready op, two-edge latency
        fu_ready = 1'b1;
        issue(4'h0, 3'd1, 4'h1, 1'b0, 3'd0, 16'd5, 1'b0, 3'd0, 16'd7);
        sb_q.push_back('{func: 4'h0, rob: 3'd1, rd: 4'h1, a: 16'd5, b: 16'd7});
        tick();
        iss_valid = 1'b0;
        chk("t1_occ_n",    32'(occupancy), 32'd1);
        chk("t1_valid_n",  32'(fu_valid), 32'd0);
        tick();
        chk("t1_valid_n1", 32'(fu_valid), 32'd1);
        chk("t1_occ_n1",   32'(occupancy), 32'd0);
        tick();
        chk("t1_drain",    32'(fu_valid), 32'd0);

        // 2: pending operand woken by CDB
        issue(4'h1, 3'd2, 4'h3, 1'b1, 3'd4, 16'h0, 1'b0, 3'd0, 16'd3);
        sb_q.push_back('{func: 4'h1, rob: 3'd2, rd: 4'h3, a: 16'd9, b: 16'd3});
        tick();
        iss_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2_idle_valid", 32'(fu_valid), 32'd0);
        end
        chk("t2_idle_occ", 32'(occupancy), 32'd1);
        cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'd9;
        tick();
        cdb_valid = 1'b0;
        chk("t2_wake_edge", 32'(fu_valid), 32'd0);
        tick();
        chk("t2_disp", 32'(fu_valid), 32'd1);
        tick();

        // 3: full RS, ignored issue, shared wakeup, oldest first
        issue(4'h2, 3'd3, 4'h4, 1'b1, 3'd5, 16'h0, 1'b0, 3'd0, 16'h0011);
        sb_q.push_back('{func: 4'h2, rob: 3'd3, rd: 4'h4, a: 16'd1, b: 16'h0011});
        tick();
        issue(4'h3, 3'd4, 4'h5, 1'b1, 3'd5, 16'h0, 1'b0, 3'd0, 16'h0022);
        sb_q.push_back('{func: 4'h3, rob: 3'd4, rd: 4'h5, a: 16'd1, b: 16'h0022});
        tick();
        chk("t3_occ_full",   32'(occupancy), 32'd2);
        chk("t3_not_ready",  32'(iss_ready), 32'd0);
        issue(4'h9, 3'd5, 4'h6, 1'b0, 3'd0, 16'h0033, 1'b0, 3'd0, 16'h0033);
        tick();
        iss_valid = 1'b0;
        chk("t3_ignored", 32'(occupancy), 32'd2);
        cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'd1;
        tick();
        cdb_valid = 1'b0;
        tick();
        chk("t3_first_rob", 32'(fu_rob), 32'd3);
        chk("t3_first_occ", 32'(occupancy), 32'd1);
        tick();
        chk("t3_second_rob", 32'(fu_rob), 32'd4);
        chk("t3_second_occ", 32'(occupancy), 32'd0);
        tick();
        chk("t3_drain", 32'(fu_valid), 32'd0);

        // 4: forwarding at insert
        issue(4'h4, 3'd6, 4'h6, 1'b1, 3'd6, 16'h0, 1'b0, 3'd0, 16'h0005);
        cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 16'h00AA;
        sb_q.push_back('{func: 4'h4, rob: 3'd6, rd: 4'h6, a: 16'h00AA, b: 16'h0005});
        tick();
        iss_valid = 1'b0; cdb_valid = 1'b0;
        tick();
        chk("t4_fwd_valid", 32'(fu_valid), 32'd1);
        tick();

        // 5: back-pressure with concurrent insert and dispatch
        fu_ready = 1'b0;
        issue(4'h5, 3'd7, 4'h7, 1'b0, 3'd0, 16'h0100, 1'b0, 3'd0, 16'h0200);
        sb_q.push_back('{func: 4'h5, rob: 3'd7, rd: 4'h7, a: 16'h0100, b: 16'h0200});
        tick();
        issue(4'h6, 3'd0, 4'h8, 1'b0, 3'd0, 16'h0300, 1'b0, 3'd0, 16'h0400);
        sb_q.push_back('{func: 4'h6, rob: 3'd0, rd: 4'h8, a: 16'h0300, b: 16'h0400});
        tick();
        iss_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t5_hold_valid", 32'(fu_valid), 32'd1);
            chk("t5_hold_rob",   32'(fu_rob), 32'd7);
            chk("t5_hold_a",     32'(fu_a), 32'h0100);
            chk("t5_hold_occ",   32'(occupancy), 32'd1);
            tick();
        end
        fu_ready = 1'b1;
        tick();
        chk("t5_second_rob", 32'(fu_rob), 32'd0);
        chk("t5_second_a",   32'(fu_a), 32'h0300);
        tick();
        chk("t5_drain", 32'(fu_valid), 32'd0);

        // 6: reset mid-operation
        fill_and_stall();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_valid", 32'(fu_valid), 32'd0);
        chk("t6_rst_occ",   32'(occupancy), 32'd0);
        chk("t6_rst_ready", 32'(iss_ready), 32'd1);
        fu_ready = 1'b1;
        tick(); tick();
        chk("t6_rst_quiet", 32'(fu_valid), 32'd0);

`ifdef RS_FLUSH_EN
        fill_and_stall();
        flush = 1'b1;
        issue(4'h8, 3'd4, 4'h9, 1'b0, 3'd0, 16'h5555, 1'b0, 3'd0, 16'h6666);
        tick();
        flush = 1'b0;
        iss_valid = 1'b0;
        chk("t6_flush_valid", 32'(fu_valid), 32'd0);
        chk("t6_flush_occ",   32'(occupancy), 32'd0);
        chk("t6_flush_ready", 32'(iss_ready), 32'd1);
        fu_ready = 1'b1;
        tick(); tick();
        chk("t6_flush_quiet", 32'(fu_valid), 32'd0);
`endif

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
